// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: base opcodes, format classes and the
// control half of the decoded bundle carried from ID to EX.
package rv_decode_pkg;

   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] OP_FENCE  = 7'h0F;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SYS  = 3'd6,
      FMT_NONE = 3'd7
   } fmt_e;

   // Width-independent part of the bundle; register addresses, immediate and
   // PC depend on module parameters and travel beside this struct.
   typedef struct packed {
      fmt_e       fmt;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic       use_rs1;
      logic       use_rs2;
      logic       wr_rd;
      logic       illegal;
   } dec_ctrl_t;

   localparam int CTRL_W = $bits(dec_ctrl_t);

   function automatic logic reg_in_range(input logic [4:0] field, input int ra_w);
      return (int'(field) < (1 << ra_w));
   endfunction

endpackage

// File: rtl/rv_field_decode.sv
// Combinational RV32I field extraction: format class, register addresses,
// funct fields, sign-extended immediate, register-use bits and illegal flag.
module rv_field_decode
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic [31:0]     instr_i,
   output dec_ctrl_t       ctrl_o,
   output logic [RA_W-1:0] rd_o,
   output logic [RA_W-1:0] rs1_o,
   output logic [RA_W-1:0] rs2_o,
   output logic [XLEN-1:0] imm_o
);

   logic [6:0] opc;
   logic [4:0] rd_f;
   logic [4:0] rs1_f;
   logic [4:0] rs2_f;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc   = instr_i[6:0];
   assign rd_f  = instr_i[11:7];
   assign f3    = instr_i[14:12];
   assign rs1_f = instr_i[19:15];
   assign rs2_f = instr_i[24:20];
   assign f7    = instr_i[31:25];

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;

   assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
   assign imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                   instr_i[20], instr_i[30:21], 1'b0};

   fmt_e fmt;
   logic known;
   logic rd_carry;
   logic rs1_carry;
   logic rs1_read;
   logic rs2_carry;
   logic f3_carry;
   logic f7_carry;
   logic range_bad;
   logic illegal;

   // "carry" means the field is forwarded; "read" means the hazard unit must
   // see it (CSR immediate forms carry rs1 as a uimm without reading it).
   always_comb begin
      fmt       = FMT_NONE;
      known     = 1'b1;
      rd_carry  = 1'b0;
      rs1_carry = 1'b0;
      rs1_read  = 1'b0;
      rs2_carry = 1'b0;
      f3_carry  = 1'b0;
      f7_carry  = 1'b0;
      case (opc)
         OP_OP: begin
            fmt       = FMT_R;
            rd_carry  = 1'b1;
            rs1_carry = 1'b1;
            rs1_read  = 1'b1;
            rs2_carry = 1'b1;
            f3_carry  = 1'b1;
            f7_carry  = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            fmt       = FMT_I;
            rd_carry  = 1'b1;
            rs1_carry = 1'b1;
            rs1_read  = 1'b1;
            f3_carry  = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            fmt       = (opc == OP_STORE) ? FMT_S : FMT_B;
            rs1_carry = 1'b1;
            rs1_read  = 1'b1;
            rs2_carry = 1'b1;
            f3_carry  = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            fmt      = FMT_U;
            rd_carry = 1'b1;
         end
         OP_JAL: begin
            fmt      = FMT_J;
            rd_carry = 1'b1;
         end
         OP_SYSTEM: begin
            fmt       = FMT_SYS;
            rd_carry  = (f3 != 3'd0);
            rs1_carry = 1'b1;
            rs1_read  = (f3[1:0] != 2'd0) && !f3[2];
            f3_carry  = 1'b1;
         end
         OP_FENCE: begin
            fmt      = FMT_I;
            f3_carry = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end

   assign range_bad = (rd_carry  && !reg_in_range(rd_f,  RA_W)) ||
                      (rs1_carry && !reg_in_range(rs1_f, RA_W)) ||
                      (rs2_carry && !reg_in_range(rs2_f, RA_W));
   assign illegal   = !known || range_bad;

   always_comb begin
      ctrl_o        = '0;
      ctrl_o.fmt    = FMT_NONE;
      ctrl_o.opcode = opc;
      rd_o          = '0;
      rs1_o         = '0;
      rs2_o         = '0;
      imm_o         = '0;
      if (illegal) begin
         ctrl_o.illegal = 1'b1;
      end else begin
         ctrl_o.fmt     = fmt;
         ctrl_o.funct3  = f3_carry ? f3 : 3'd0;
         ctrl_o.funct7  = f7_carry ? f7 : 7'd0;
         ctrl_o.use_rs1 = rs1_read  && (rs1_f != 5'd0);
         ctrl_o.use_rs2 = rs2_carry && (rs2_f != 5'd0);
         ctrl_o.wr_rd   = rd_carry  && (rd_f  != 5'd0);
         if (rd_carry)  rd_o  = rd_f[RA_W-1:0];
         if (rs1_carry) rs1_o = rs1_f[RA_W-1:0];
         if (rs2_carry) rs2_o = rs2_f[RA_W-1:0];
         case (fmt)
            FMT_I, FMT_SYS: imm_o = imm_i;
            FMT_S:          imm_o = imm_s;
            FMT_B:          imm_o = imm_b;
            FMT_U:          imm_o = imm_u;
            FMT_J:          imm_o = imm_j;
            default:        imm_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I ID stage: decodes the incoming instruction into a registered ID/EX
// bundle, backed by one skid entry so in_ready never depends on out_ready.
module id_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [2:0]      out_fmt,
   output logic [6:0]      out_opcode,
   output logic [RA_W-1:0] out_rd,
   output logic [RA_W-1:0] out_rs1,
   output logic [RA_W-1:0] out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic            out_use_rs1,
   output logic            out_use_rs2,
   output logic            out_wr_rd,
   output logic            out_illegal
);

   // Handshake: a beat moves on a side when valid and ready are both high at
   // the rising edge; valid holds and data stays stable until it does.
   localparam int BW = PC_W + CTRL_W + 3 * RA_W + XLEN;

   dec_ctrl_t       dec_ctrl;
   logic [RA_W-1:0] dec_rd;
   logic [RA_W-1:0] dec_rs1;
   logic [RA_W-1:0] dec_rs2;
   logic [XLEN-1:0] dec_imm;
   logic [BW-1:0]   in_bundle;

   rv_field_decode #(
      .XLEN (XLEN),
      .RA_W (RA_W)
   ) u_field_decode (
      .instr_i (in_instr),
      .ctrl_o  (dec_ctrl),
      .rd_o    (dec_rd),
      .rs1_o   (dec_rs1),
      .rs2_o   (dec_rs2),
      .imm_o   (dec_imm)
   );

   assign in_bundle = {in_pc, dec_ctrl, dec_rd, dec_rs1, dec_rs2, dec_imm};

   logic [BW-1:0] out_q;
   logic [BW-1:0] out_d;
   logic [BW-1:0] skid_q;
   logic [BW-1:0] skid_d;
   logic          out_v_q;
   logic          out_v_d;
   logic          skid_v_q;
   logic          skid_v_d;
   logic          accept;
   logic          out_free;

   assign in_ready = !skid_v_q;
   assign accept   = in_valid && in_ready && !flush;
   assign out_free = !out_v_q || out_ready;

   // The skid entry always drains before a new beat so order is preserved.
   always_comb begin
      out_d    = out_q;
      skid_d   = skid_q;
      out_v_d  = out_v_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         out_v_d  = 1'b0;
         skid_v_d = 1'b0;
      end else if (out_free) begin
         if (skid_v_q) begin
            out_d    = skid_q;
            out_v_d  = 1'b1;
            skid_v_d = 1'b0;
         end else if (accept) begin
            out_d   = in_bundle;
            out_v_d = 1'b1;
         end else begin
            out_v_d = 1'b0;
         end
      end else if (accept) begin
         skid_d   = in_bundle;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         out_q    <= out_d;
         skid_q   <= skid_d;
         out_v_q  <= out_v_d;
         skid_v_q <= skid_v_d;
      end
   end

   dec_ctrl_t out_ctrl;

   assign {out_pc, out_ctrl, out_rd, out_rs1, out_rs2, out_imm} = out_q;

   assign out_valid   = out_v_q;
   assign out_fmt     = out_ctrl.fmt;
   assign out_opcode  = out_ctrl.opcode;
   assign out_funct3  = out_ctrl.funct3;
   assign out_funct7  = out_ctrl.funct7;
   assign out_use_rs1 = out_ctrl.use_rs1;
   assign out_use_rs2 = out_ctrl.use_rs2;
   assign out_wr_rd   = out_ctrl.wr_rd;
   assign out_illegal = out_ctrl.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: a table of decoded instructions plus
// hand-written stall, ordering, flush and reset sequences.
module tb_id_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [2:0]  out_fmt;
   logic [6:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [31:0] out_imm;
   logic        out_use_rs1;
   logic        out_use_rs2;
   logic        out_wr_rd;
   logic        out_illegal;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   id_decode_stage #(.XLEN(32), .RA_W(5), .PC_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_fmt     (out_fmt),
      .out_opcode  (out_opcode),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_funct3  (out_funct3),
      .out_funct7  (out_funct7),
      .out_imm     (out_imm),
      .out_use_rs1 (out_use_rs1),
      .out_use_rs2 (out_use_rs2),
      .out_wr_rd   (out_wr_rd),
      .out_illegal (out_illegal)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        u1;
      logic        u2;
      logic        wr;
      logic        ill;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] fmt,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic u1, input logic u2, input logic wr,
                               input logic ill);
      vec_t v;
      v.instr = instr; v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm; v.u1 = u1; v.u2 = u2; v.wr = wr;
      v.ill = ill;
      return v;
   endfunction

   // Drive one beat at the falling edge; caller decides when to drop it.
   task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
   endtask

   initial begin
      logic [31:0] op_word;
      logic        c_taken;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0;

      //                instr          fmt  rd  rs1 rs2 f3 f7     imm         u1 u2 wr ill
      vecs[0]  = mk(32'h002081B3, 3'd0, 3,  1,  2,  0, 7'h00, 32'h0,        1, 1, 1, 0);
      vecs[1]  = mk(32'hFFF00293, 3'd1, 5,  0,  0,  0, 7'h00, 32'hFFFFFFFF, 0, 0, 1, 0);
      vecs[2]  = mk(32'h0020A423, 3'd2, 0,  1,  2,  2, 7'h00, 32'h8,        1, 1, 0, 0);
      vecs[3]  = mk(32'hFE208EE3, 3'd3, 0,  1,  2,  0, 7'h00, 32'hFFFFFFFC, 1, 1, 0, 0);
      vecs[4]  = mk(32'h008000EF, 3'd5, 1,  0,  0,  0, 7'h00, 32'h8,        0, 0, 1, 0);
      vecs[5]  = mk(32'h0000007F, 3'd7, 0,  0,  0,  0, 7'h00, 32'h0,        0, 0, 0, 1);
      vecs[6]  = mk(32'h123452B7, 3'd4, 5,  0,  0,  0, 7'h00, 32'h12345000, 0, 0, 1, 0);
      vecs[7]  = mk(32'h300091F3, 3'd6, 3,  1,  0,  1, 7'h00, 32'h300,      1, 0, 1, 0);
      vecs[8]  = mk(32'h00000073, 3'd6, 0,  0,  0,  0, 7'h00, 32'h0,        0, 0, 0, 0);
      vecs[9]  = mk(32'h0FF0000F, 3'd1, 0,  0,  0,  0, 7'h00, 32'hFF,       0, 0, 0, 0);
      vecs[10] = mk(32'hFFC12303, 3'd1, 6,  2,  0,  2, 7'h00, 32'hFFFFFFFC, 1, 0, 1, 0);
      vecs[11] = mk(32'h40208033, 3'd0, 0,  1,  2,  0, 7'h20, 32'h0,        1, 1, 0, 0);

      repeat (2) @(negedge clk);
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.in_ready", 64'(in_ready), 64'd1);
      chk("reset.out_pc", 64'(out_pc), 64'd0);
      chk("reset.out_imm", 64'(out_imm), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].instr, 32'h1000 + 32'(i * 4));
         @(negedge clk);
         in_valid = 1'b0;
         op_word = vecs[i].instr;
         chk($sformatf("v%0d.valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d.pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
         chk($sformatf("v%0d.opcode", i), 64'(out_opcode), 64'(op_word[6:0]));
         chk($sformatf("v%0d.fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
         chk($sformatf("v%0d.rd", i), 64'(out_rd), 64'(vecs[i].rd));
         chk($sformatf("v%0d.rs1", i), 64'(out_rs1), 64'(vecs[i].rs1));
         chk($sformatf("v%0d.rs2", i), 64'(out_rs2), 64'(vecs[i].rs2));
         chk($sformatf("v%0d.f3", i), 64'(out_funct3), 64'(vecs[i].f3));
         chk($sformatf("v%0d.f7", i), 64'(out_funct7), 64'(vecs[i].f7));
         chk($sformatf("v%0d.imm", i), 64'(out_imm), 64'(vecs[i].imm));
         chk($sformatf("v%0d.use_rs1", i), 64'(out_use_rs1), 64'(vecs[i].u1));
         chk($sformatf("v%0d.use_rs2", i), 64'(out_use_rs2), 64'(vecs[i].u2));
         chk($sformatf("v%0d.wr_rd", i), 64'(out_wr_rd), 64'(vecs[i].wr));
         chk($sformatf("v%0d.illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      end
      @(negedge clk);
      chk("bubble.out_valid", 64'(out_valid), 64'd0);

      // Stall: A held in output, B in skid, C refused until the skid drains.
      out_ready = 1'b0;
      drive(32'h002081B3, 32'hA0);
      drive(32'hFFF00293, 32'hB0);
      drive(32'h0020A423, 32'hC0);
      chk("stall.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("stall.hold_pc", 64'(out_pc), 64'hA0);
      chk("stall.hold_valid", 64'(out_valid), 64'd1);
      chk("stall.hold_fmt", 64'(out_fmt), 64'd0);
      chk("stall.in_ready2", 64'(in_ready), 64'd0);
      exp_q.push_back(32'hA0);
      exp_q.push_back(32'hB0);
      exp_q.push_back(32'hC0);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         c_taken = in_valid && in_ready;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("order.extra_beat", 64'(out_pc), 64'hFFFFFFFF);
            end else begin
               chk($sformatf("order.beat%0d", k), 64'(out_pc), 64'(exp_q.pop_front()));
            end
         end
         @(posedge clk);
         #1;
         if (c_taken) in_valid = 1'b0;
         @(negedge clk);
      end
      chk("order.drained", 64'(exp_q.size()), 64'd0);
      chk("order.in_valid_dropped", 64'(in_valid), 64'd0);

      // Flush beats a same-cycle arrival and empties both entries.
      out_ready = 1'b0;
      drive(32'h002081B3, 32'hD0);
      drive(32'hFFF00293, 32'hD4);
      drive(32'h0020A423, 32'hD8);
      chk("flush.skid_full", 64'(in_ready), 64'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush.out_valid", 64'(out_valid), 64'd0);
      chk("flush.in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush.no_leak", 64'(out_valid), 64'd0);

      // Reset with both entries full and a beat arriving drops everything.
      out_ready = 1'b0;
      drive(32'hFE208EE3, 32'hE0);
      drive(32'h008000EF, 32'hE4);
      drive(32'h123452B7, 32'hE8);
      reset = 1'b1;
      @(negedge clk);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_pc", 64'(out_pc), 64'd0);
      chk("rst.out_imm", 64'(out_imm), 64'd0);
      chk("rst.out_rd", 64'(out_rd), 64'd0);
      chk("rst.out_opcode", 64'(out_opcode), 64'd0);
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst.stays_empty", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
